rv32_decode_stage: RTL and testbench

//  Decode pipeline stage between instruction fetch and the immediate mux / register-file read.

---
 rtl/rv32_decode_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: classifies the fetched opcode and registers instruction, PC and
// control fields behind a single-entry valid/ready register with flush.
module rv32_decode_stage #(
  parameter logic [31:0] NOP_INSTR    = 32'h00000013,
  parameter bit          ENABLE_ZICSR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  imm_sel_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        illegal_out
);

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       rd_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Every listed opcode ends in 2'b11, so the full 7-bit match also rejects
  // compressed/reserved encodings with instr[1:0] != 2'b11.
  function automatic ctrl_t decode(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    ctrl_t      c;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    ill = 1'b0;
    c   = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        c.imm_sel  = IMM_U;
        c.rd_write = 1'b1;
      end
      OPC_JAL: begin
        c.imm_sel  = IMM_J;
        c.rd_write = 1'b1;
        c.jump     = 1'b1;
      end
      OPC_JALR: begin
        c.imm_sel  = IMM_I;
        c.rd_write = 1'b1;
        c.jump     = 1'b1;
        ill        = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        c.imm_sel = IMM_B;
        c.branch  = 1'b1;
        ill       = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        c.imm_sel  = IMM_I;
        c.rd_write = 1'b1;
        c.mem_read = 1'b1;
        ill        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        c.imm_sel   = IMM_S;
        c.mem_write = 1'b1;
        ill         = (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        c.rd_write = 1'b1;
        if (f3 == 3'b001) begin
          c.imm_sel = IMM_SHAMT;
          ill       = (f7 != F7_ZERO);
        end else if (f3 == 3'b101) begin
          c.imm_sel = IMM_SHAMT;
          ill       = (f7 != F7_ZERO) && (f7 != F7_ALT);
        end else begin
          c.imm_sel = IMM_I;
        end
      end
      OPC_OP: begin
        c.imm_sel  = IMM_I;
        c.rd_write = 1'b1;
        ill        = (f7 != F7_ZERO) && (f7 != F7_ALT);
      end
      OPC_MISC: begin
        c.imm_sel = IMM_I;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          c.imm_sel = IMM_I;
        end else if (!ENABLE_ZICSR || (f3 == 3'b100)) begin
          ill = 1'b1;
        end else begin
          c.imm_sel  = f3[2] ? IMM_ZIMM : IMM_I;
          c.rd_write = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // Illegal words still travel down the pipe so the trap is raised in order.
    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    if (instr[11:7] == 5'd0) c.rd_write = 1'b0;
    return c;
  endfunction

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  ctrl_t       ctrl_q, ctrl_d;
  ctrl_t       dec;
  logic        accept;

  assign ready_out = !valid_q || ready_in;
  assign accept    = valid_in && ready_out;

  always_comb begin
    dec     = decode(instr_in);
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush_in || (!accept && ready_in && valid_q)) begin
      // Bubble: same as reset except the PC keeps its last value.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      rs1_d   = 5'd0;
      rs2_d   = 5'd0;
      rd_d    = 5'd0;
      ctrl_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
      rs1_d   = instr_in[19:15];
      rs2_d   = instr_in[24:20];
      rd_d    = instr_in[11:7];
      ctrl_d  = dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_out     = valid_q;
  assign instr_out     = instr_q;
  assign pc_out        = pc_q;
  assign rs1_out       = rs1_q;
  assign rs2_out       = rs2_q;
  assign rd_out        = rd_q;
  assign imm_sel_out   = ctrl_q.imm_sel;
  assign rd_write_out  = ctrl_q.rd_write;
  assign mem_read_out  = ctrl_q.mem_read;
  assign mem_write_out = ctrl_q.mem_write;
  assign branch_out    = ctrl_q.branch;
  assign jump_out      = ctrl_q.jump;
  assign illegal_out   = ctrl_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: directed instruction words with hand-decoded
// expectations; a second instance with ENABLE_ZICSR=0 shares the same stimulus.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush_in, valid_in, ready_in;
  logic [31:0] instr_in, pc_in;
  logic        ready_out, valid_out;
  logic [31:0] instr_out, pc_out;
  logic [2:0]  imm_sel_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic        rd_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out;

  logic        z_ready_out, z_valid_out;
  logic [31:0] z_instr_out, z_pc_out;
  logic [2:0]  z_imm_sel_out;
  logic [4:0]  z_rs1_out, z_rs2_out, z_rd_out;
  logic        z_rd_write_out, z_mem_read_out, z_mem_write_out, z_branch_out, z_jump_out;
  logic        z_illegal_out;

  rv32_decode_stage dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in), .ready_out(ready_out),
    .instr_in(instr_in), .pc_in(pc_in), .valid_out(valid_out), .ready_in(ready_in),
    .instr_out(instr_out), .pc_out(pc_out), .imm_sel_out(imm_sel_out), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .branch_out(branch_out),
    .jump_out(jump_out), .illegal_out(illegal_out)
  );

  rv32_decode_stage #(.ENABLE_ZICSR(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in), .ready_out(z_ready_out),
    .instr_in(instr_in), .pc_in(pc_in), .valid_out(z_valid_out), .ready_in(ready_in),
    .instr_out(z_instr_out), .pc_out(z_pc_out), .imm_sel_out(z_imm_sel_out),
    .rs1_out(z_rs1_out), .rs2_out(z_rs2_out), .rd_out(z_rd_out),
    .rd_write_out(z_rd_write_out), .mem_read_out(z_mem_read_out),
    .mem_write_out(z_mem_write_out), .branch_out(z_branch_out), .jump_out(z_jump_out),
    .illegal_out(z_illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rdw, mr, mw, br, jp, ill, illnz;
  } exp_t;

  exp_t tbl [0:12];
  exp_t sbq [$];
  exp_t m_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   pop_n   = 0;
  int   pop_cyc [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] ins, input logic [2:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rdw, input logic mr,
                              input logic mw, input logic br, input logic jp,
                              input logic ill, input logic illnz);
    exp_t e;
    e.instr = ins; e.pc = 32'd0; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rdw = rdw; e.mr = mr; e.mw = mw; e.br = br; e.jp = jp; e.ill = ill; e.illnz = illnz;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compares whatever the stage hands downstream against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got instr %h expected nothing", instr_out);
      end else begin
        m_e = sbq.pop_front();
        if (pop_n < 16) pop_cyc[pop_n] = cyc;
        pop_n++;
        chk("instr", instr_out, m_e.instr);
        chk("pc", pc_out, m_e.pc);
        chk("imm_sel", 32'(imm_sel_out), 32'(m_e.imm));
        chk("rs1", 32'(rs1_out), 32'(m_e.rs1));
        chk("rs2", 32'(rs2_out), 32'(m_e.rs2));
        chk("rd", 32'(rd_out), 32'(m_e.rd));
        chk("rd_write", 32'(rd_write_out), 32'(m_e.rdw));
        chk("mem_read", 32'(mem_read_out), 32'(m_e.mr));
        chk("mem_write", 32'(mem_write_out), 32'(m_e.mw));
        chk("branch", 32'(branch_out), 32'(m_e.br));
        chk("jump", 32'(jump_out), 32'(m_e.jp));
        chk("illegal", 32'(illegal_out), 32'(m_e.ill));
        chk("nz_valid", 32'(z_valid_out), 32'd1);
        chk("nz_illegal", 32'(z_illegal_out), 32'(m_e.illnz));
      end
    end
  end

  task automatic send(input int idx, input logic [31:0] pc);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    valid_in = 1'b1;
    instr_in = tbl[idx].instr;
    pc_in    = pc;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (ready_out) begin
        e    = tbl[idx];
        e.pc = pc;
        sbq.push_back(e);
        ok   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got no ready_out for %h expected accept within 20 cycles",
               tbl[idx].instr);
    end
  endtask

  initial begin
    //                 instr          imm     rs1   rs2    rd    rdw mr mw br jp il nz
    tbl[0]  = mk(32'hFFF00093, 3'b000, 5'd0, 5'd31, 5'd1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h00112023, 3'b001, 5'd2, 5'd1,  5'd0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(32'h00208463, 3'b010, 5'd1, 5'd2,  5'd8, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(32'h008000EF, 3'b100, 5'd0, 5'd8,  5'd1, 1, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(32'h123450B7, 3'b011, 5'd8, 5'd3,  5'd1, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(32'h00309093, 3'b101, 5'd1, 5'd3,  5'd1, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(32'h3002D0F3, 3'b110, 5'd5, 5'd0,  5'd1, 1, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(32'h00000000, 3'b000, 5'd0, 5'd0,  5'd0, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(32'h00012283, 3'b000, 5'd2, 5'd0,  5'd5, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(32'h00000073, 3'b000, 5'd0, 5'd0,  5'd0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(32'h4030D093, 3'b101, 5'd1, 5'd3,  5'd1, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(32'h00000013, 3'b000, 5'd0, 5'd0,  5'd0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(32'h40309093, 3'b000, 5'd1, 5'd3,  5'd1, 0, 0, 0, 0, 0, 1, 1);

    reset = 1'b1; flush_in = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
    instr_in = 32'hFFF00093; pc_in = 32'h0000_0100;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_instr", instr_out, 32'h00000013);
    chk("reset_ready", 32'(ready_out), 32'd1);
    chk("reset_pc", pc_out, 32'd0);
    chk("reset_imm", 32'(imm_sel_out), 32'd0);
    chk("reset_rdw", 32'(rd_write_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0;

    // Back-to-back stream.
    send(0, 32'h100);
    send(1, 32'h104);
    send(2, 32'h108);
    send(3, 32'h10C);
    send(4, 32'h110);
    send(5, 32'h114);
    send(6, 32'h118);

    // Downstream stall for three cycles while the next word waits.
    ready_in = 1'b0; valid_in = 1'b1; instr_in = 32'h00000000; pc_in = 32'h11C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 32'(ready_out), 32'd0);
      chk("stall_valid", 32'(valid_out), 32'd1);
      chk("stall_instr", instr_out, 32'h3002D0F3);
      chk("stall_imm", 32'(imm_sel_out), 32'd6);
      chk("stall_pc", pc_out, 32'h118);
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    send(7, 32'h11C);
    @(negedge clk);
    @(posedge clk); #1;

    // Flush while holding an instruction and offering another.
    ready_in = 1'b0;
    send(8, 32'h120);
    flush_in = 1'b1; valid_in = 1'b1; instr_in = 32'h00000073; pc_in = 32'h1FC;
    @(posedge clk); #1;
    void'(sbq.pop_back());
    flush_in = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_instr", instr_out, 32'h00000013);
    chk("flush_pc_hold", pc_out, 32'h120);
    chk("flush_rd", 32'(rd_out), 32'd0);
    chk("flush_mem_read", 32'(mem_read_out), 32'd0);
    chk("flush_ready", 32'(ready_out), 32'd1);
    @(posedge clk); #1;

    ready_in = 1'b1;
    send(8, 32'h124);
    send(9, 32'h128);
    send(10, 32'h12C);
    send(11, 32'h130);
    send(12, 32'h134);
    for (int n = 0; n < 10 && sbq.size() != 0; n++) @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    chk("drain_valid", 32'(valid_out), 32'd0);
    chk("drain_instr", instr_out, 32'h00000013);
    chk("drain_pc_hold", pc_out, 32'h134);
    chk("drain_illegal", 32'(illegal_out), 32'd0);
    chk("stream_no_gaps", 32'(pop_cyc[5] - pop_cyc[0]), 32'd5);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stall.
    ready_in = 1'b0;
    send(4, 32'h200);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 32'(valid_out), 32'd0);
    chk("areset_instr", instr_out, 32'h00000013);
    chk("areset_pc", pc_out, 32'd0);
    chk("areset_rdw", 32'(rd_write_out), 32'd0);
    chk("areset_ready", 32'(ready_out), 32'd1);
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0; ready_in = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
